// File: rtl/noc_pkg.sv
// Shared NoC parameters and the PE injection FSM state type.
package noc_pkg;

    localparam int FLIT_W     = 20;
    localparam int PE_CREDITS = 7;

    typedef enum logic {
        INJ_IDLE   = 1'b0,
        INJ_LOCKED = 1'b1
    } inj_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping mod N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] rot;
    logic [N-1:0] pick;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot  = N'({req, req} >> ptr);
        pick = rot & (~rot + ONE);
        gnt  = N'(({pick, pick} << ptr) >> N);
    end

endmodule

// File: rtl/pe_inject_arbiter.sv
// Packet-atomic round-robin sharing of one credit-gated NoC injection port.
// Optional per-source flit counters are built when PE_INJ_ARB_STATS_EN is defined.
module pe_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = FLIT_W,
    parameter int CREDITS = PE_CREDITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    gnt,
    input  logic            ci,
    output logic [DW-1:0]   dataout,
    output logic            out_valid,
    output logic            busy,
    output logic            cred_err,
    output logic [N*16-1:0] stat_flits
);

    localparam int             PW       = $clog2(N);
    localparam int             CW       = $clog2(CREDITS + 1);
    localparam logic [N-1:0]   ONE      = N'(1);
    localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);

    inj_state_e     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cred_q, cred_d;
    logic           cred_err_q, cred_err_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  dataout_q, dataout_d;

    logic [N-1:0]   arb_req, arb_win;
    logic [PW-1:0]  arb_ptr, win_idx;
    logic           granted, win_last;
    logic [DW-1:0]  win_data;

    // While LOCKED the arbiter only sees the owner, so the pointer value does not matter.
    assign arb_req = (state_q == INJ_LOCKED) ? (req & (ONE << owner_q)) : req;
    assign arb_ptr = (state_q == INJ_LOCKED) ? owner_q : ptr_q;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req (arb_req),
        .ptr (arb_ptr),
        .gnt (arb_win)
    );

    assign gnt     = (cred_q != '0) ? arb_win : '0;
    assign granted = |gnt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        win_idx  = '0;
        win_last = 1'b0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_idx  = PW'(i);
                win_last = req_last[i];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cred_d      = cred_q;
        cred_err_d  = cred_err_q;
        out_valid_d = granted;
        dataout_d   = granted ? win_data : dataout_q;

        if (granted) begin
            if (win_last) begin
                state_d = INJ_IDLE;
                ptr_d   = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
            end else begin
                state_d = INJ_LOCKED;
                owner_d = win_idx;
            end
        end

        // A grant and a credit return in the same cycle cancel out.
        if (granted && !ci) begin
            cred_d = cred_q - CW'(1);
        end else if (!granted && ci) begin
            if (cred_q == CRED_MAX) begin
                cred_err_d = 1'b1;
            end else begin
                cred_d = cred_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INJ_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cred_q      <= CRED_MAX;
            cred_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dataout_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cred_q      <= cred_d;
            cred_err_q  <= cred_err_d;
            out_valid_q <= out_valid_d;
            dataout_q   <= dataout_d;
        end
    end

    assign busy      = (state_q == INJ_LOCKED);
    assign cred_err  = cred_err_q;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;

`ifdef PE_INJ_ARB_STATS_EN
    logic [N-1:0][15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_flits = stat_q;
`else
    assign stat_flits = '0;
`endif

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed bench for pe_inject_arbiter with a per-cycle behavioural model comparison.
`timescale 1ns/1ps
module tb_pe_inject_arbiter;
    import noc_pkg::*;

    localparam int N       = 4;
    localparam int DW      = FLIT_W;
    localparam int CREDITS = PE_CREDITS;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic [N-1:0]    req      = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            ci       = 1'b0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   dataout;
    logic            out_valid, busy, cred_err;
    logic [N*16-1:0] stat_flits;

    int          n_checks = 0;
    int          n_errs   = 0;
    int unsigned seq      = 0;

    pe_inject_arbiter #(.N(N), .DW(DW), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .ci         (ci),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .busy       (busy),
        .cred_err   (cred_err),
        .stat_flits (stat_flits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_cred, m_ptr, m_owner, mg;
    bit            m_locked, m_err, m_ov;
    logic [DW-1:0] m_dout;
    int            m_stat [N];

    // Index of the requester that must be granted now, or -1.
    function automatic int model_pick();
        if (m_cred == 0) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cred = CREDITS; m_ptr = 0; m_owner = 0;
            m_locked = 0; m_err = 0; m_ov = 0; m_dout = '0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else begin
            mg = model_pick();
            m_ov = (mg >= 0);
            if (mg >= 0) begin
                m_dout = req_data[mg*DW +: DW];
                if (m_stat[mg] < 65535) m_stat[mg] = m_stat[mg] + 1;
                if (req_last[mg]) begin
                    m_locked = 0;
                    m_ptr    = (mg + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = mg;
                end
            end
            if (mg >= 0 && !ci) m_cred = m_cred - 1;
            else if (mg < 0 && ci) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred = m_cred + 1;
            end
        end
    end

    logic [N-1:0]    exp_gnt;
    logic [N*16-1:0] exp_stat;
    int              cp;

    always @(negedge clk) begin
        if (rst) begin
            cp = model_pick();
            exp_gnt = '0;
            if (cp >= 0) exp_gnt[cp] = 1'b1;
            exp_stat = '0;
`ifdef PE_INJ_ARB_STATS_EN
            for (int i = 0; i < N; i++) exp_stat[i*16 +: 16] = 16'(m_stat[i]);
`endif
            check("model_gnt",       gnt,        exp_gnt);
            check("model_out_valid", out_valid,  m_ov);
            check("model_dataout",   dataout,    m_dout);
            check("model_busy",      busy,       m_locked);
            check("model_cred_err",  cred_err,   m_err);
            check("model_stat",      stat_flits, exp_stat);
        end
    end

    // ---------------- stimulus ----------------
    // One clock cycle: drive inputs, capture gnt mid-cycle, return at posedge+1.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic c,
                       output logic [N-1:0] g);
        seq++;
        req = r; req_last = l; ci = c;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'({4'(i), 16'(seq)});
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; req_last = '0; ci = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [N-1:0] g;
    int           rr_order [5] = '{0, 1, 2, 3, 0};
    int           tail_order [9] = '{0, 1, 2, 3, 0, 1, 2, -1, -1};
    logic [N-1:0] exp_g;

    initial begin
        #2;
        do_reset();
        check("reset_out_valid", out_valid,  1'b0);
        check("reset_busy",      busy,       1'b0);
        check("reset_cred_err",  cred_err,   1'b0);
        check("reset_dataout",   dataout,    '0);
        check("reset_stat",      stat_flits, '0);
        check("reset_gnt",       gnt,        '0);

        // Credit return with a full counter right after reset.
        cyc(4'b0000, 4'b0000, 1'b1, g);
        check("ovf_no_gnt", g, 4'b0000);
        check("ovf_cred_err_set", cred_err, 1'b1);

        // Credit exhaustion: the overflow must not have added a credit.
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0001, 4'b0001, 1'b0, g);
            check($sformatf("exhaust_gnt_%0d", k), g, (k < 7) ? 4'b0001 : 4'b0000);
        end
        cyc(4'b0001, 4'b0001, 1'b1, g);
        check("ci_at_zero_no_gnt", g, 4'b0000);
        cyc(4'b0001, 4'b0001, 1'b0, g);
        check("one_more_gnt", g, 4'b0001);
        cyc(4'b0001, 4'b0001, 1'b0, g);
        check("then_empty", g, 4'b0000);
        check("cred_err_sticky", cred_err, 1'b1);

        do_reset();
        check("cred_err_cleared", cred_err, 1'b0);

        // Round-robin with steady credit return.
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 4'b1111, 1'b1, g);
            exp_g = '0;
            exp_g[rr_order[k]] = 1'b1;
            check($sformatf("rr_gnt_%0d", k), g, exp_g);
            check($sformatf("rr_data_%0d", k), dataout, DW'({4'(rr_order[k]), 16'(seq)}));
            check($sformatf("rr_valid_%0d", k), out_valid, 1'b1);
        end
        cyc(4'b0010, 4'b0010, 1'b1, g);
        check("rr_align", g, 4'b0010);

        // Packet atomicity on requester 2.
        cyc(4'b1111, 4'b0000, 1'b1, g);
        check("atom_g0", g, 4'b0100);
        check("atom_busy0", busy, 1'b1);
        cyc(4'b1111, 4'b0000, 1'b1, g);
        check("atom_g1", g, 4'b0100);
        check("atom_busy1", busy, 1'b1);
        cyc(4'b1111, 4'b0100, 1'b1, g);
        check("atom_g2", g, 4'b0100);
        check("atom_busy2", busy, 1'b0);
        cyc(4'b1111, 4'b1111, 1'b1, g);
        check("atom_next", g, 4'b1000);

        // Owner stall on requester 1 (no credit return, counter at 7).
        cyc(4'b0010, 4'b0000, 1'b0, g);
        check("stall_lock", g, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1101, 4'b1111, 1'b0, g);
            check($sformatf("stall_gnt_%0d", k), g, 4'b0000);
            check($sformatf("stall_busy_%0d", k), busy, 1'b1);
        end
        cyc(4'b1111, 4'b0010, 1'b0, g);
        check("stall_resume", g, 4'b0010);
        check("stall_unlock", busy, 1'b0);
        cyc(4'b1111, 4'b1111, 1'b0, g);
        check("stall_after", g, 4'b0100);

        // Lock on requester 0 with credits dropping to 3, then reset mid-packet.
        cyc(4'b0001, 4'b0000, 1'b0, g);
        check("mid_lock", g, 4'b0001);
        check("mid_valid", out_valid, 1'b1);
        check("mid_busy", busy, 1'b1);
        req = '0;
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_gnt", gnt, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 9; k++) begin
            cyc(4'b1111, 4'b1111, 1'b0, g);
            exp_g = '0;
            if (tail_order[k] >= 0) exp_g[tail_order[k]] = 1'b1;
            check($sformatf("post_reset_gnt_%0d", k), g, exp_g);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
